// File: rtl/k2_pkg.sv
// k2_pkg: shared types and constants for the K2 multi-cycle accumulator core.
//   state_t  - FETCH / EXEC / MEM sequencer states
//   instr_t  - 8-bit instruction word {j, c, d[1:0], s, imm[2:0]}
//   D_*      - destination field encodings
//   needs_mem() - true when an instruction must visit the MEM state
package k2_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2
    } state_t;

    typedef struct packed {
        logic       j;
        logic       c;
        logic [1:0] d;
        logic       s;
        logic [2:0] imm;
    } instr_t;

    localparam logic [1:0] D_RA  = 2'b00;
    localparam logic [1:0] D_RB  = 2'b01;
    localparam logic [1:0] D_RO  = 2'b10;
    localparam logic [1:0] D_MEM = 2'b11;

    // Stores (D=11) and memory-sourced loads (S=1,C=1) need a data access.
    function automatic logic needs_mem(input instr_t i);
        return (!i.j) && ((i.d == D_MEM) || (i.s && i.c));
    endfunction

endpackage

// File: rtl/k2_mc_core_if.sv
// k2_mc_core_if: instruction- and data-memory handshake bundle.
//   imem_req/imem_addr (master out), imem_valid/imem_rdata (master in)
//   dmem_req/dmem_we/dmem_addr/dmem_wdata (master out), dmem_valid/dmem_rdata (master in)
// Parameters PC_W and DATA_W must match the core instance.
interface k2_mc_core_if #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 8
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_valid;
    logic [7:0]        imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [2:0]        dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_valid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_valid, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_valid, dmem_rdata
    );
endinterface

// File: rtl/k2_alu.sv
// k2_alu: combinational add/subtract for the K2 core.
//   a, b  in  DATA_W  operands
//   sub   in  1       0: a+b, 1: a+~b+1
//   y     out DATA_W  truncated result
//   cf    out 1       carry-out of bit DATA_W-1
//   zf    out 1       result == 0
module k2_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] y,
    output logic              cf,
    output logic              zf
);
    logic [DATA_W-1:0] b_op_s;
    logic [DATA_W:0]   sum_s;

    // One adder serves both ops: subtraction is a + ~b with carry-in 1.
    always_comb begin
        b_op_s = sub ? ~b : b;
        sum_s  = {1'b0, a} + {1'b0, b_op_s} + {{DATA_W{1'b0}}, sub};
    end

    assign y  = sum_s[DATA_W-1:0];
    assign cf = sum_s[DATA_W];
    assign zf = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
endmodule

// File: rtl/k2_mc_core.sv
// k2_mc_core: multi-cycle K2 accumulator core (FETCH -> EXEC -> (MEM ->) FETCH).
//   clk, rst_n  clock / asynchronous active-low reset
//   run         1: keep fetching; 0: stop at the next FETCH boundary
//   bus         k2_mc_core_if.master: instruction and data memory handshakes
//   pc, ra, ro  program counter, register A, output register
//   cf, zf      carry / zero flags (updated only by ALU writes)
//   busy        state != FETCH or a fetch request is outstanding
// Optional macro K2_TRACE_EN adds retire_valid / retire_pc / retire_instr.
// Requests are registered: each is raised on the edge that enters its wait
// state, so a memory answering in the same cycle gives 2 cycles/instruction.
module k2_mc_core
    import k2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    k2_mc_core_if.master      bus,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] ra,
    output logic [DATA_W-1:0] ro,
    output logic              cf,
    output logic              zf,
    output logic              busy
`ifdef K2_TRACE_EN
    ,
    output logic              retire_valid,
    output logic [PC_W-1:0]   retire_pc,
    output logic [7:0]        retire_instr
`endif
);
    state_t            state_r;
    instr_t            instr_r;
    logic [PC_W-1:0]   pc_r;
    logic [DATA_W-1:0] ra_r;
    logic [DATA_W-1:0] rb_r;
    logic [DATA_W-1:0] ro_r;
    logic              cf_r;
    logic              zf_r;
    logic              imem_req_r;
    logic              dmem_req_r;
    logic              dmem_we_r;
    logic [2:0]        dmem_addr_r;
    logic [DATA_W-1:0] dmem_wdata_r;

    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   imm_pc_s;
    logic [DATA_W-1:0] exec_val_s;
    logic [DATA_W-1:0] alu_y_s;
    logic              alu_cf_s;
    logic              alu_zf_s;
    logic              alu_dest_s;

    k2_alu #(.DATA_W(DATA_W)) u_alu (
        .a   (ra_r),
        .b   (rb_r),
        .sub (instr_r.imm[2]),
        .y   (alu_y_s),
        .cf  (alu_cf_s),
        .zf  (alu_zf_s)
    );

    // Next-pc candidates and the register value produced by a non-memory EXEC.
    always_comb begin
        pc_inc_s   = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        imm_pc_s   = {{(PC_W-3){1'b0}}, instr_r.imm};
        exec_val_s = instr_r.s ? {{(DATA_W-3){1'b0}}, instr_r.imm} : alu_y_s;
        alu_dest_s = (!instr_r.s) && ((instr_r.d == D_RA) || (instr_r.d == D_RB));
    end

    // Sequencer, register file, flags, pc and registered memory requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= FETCH;
            instr_r      <= '{j: 1'b0, c: 1'b0, d: 2'b00, s: 1'b0, imm: 3'b000};
            pc_r         <= {PC_W{1'b0}};
            ra_r         <= {DATA_W{1'b0}};
            rb_r         <= {DATA_W{1'b0}};
            ro_r         <= {DATA_W{1'b0}};
            cf_r         <= 1'b0;
            zf_r         <= 1'b0;
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 3'b000;
            dmem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                FETCH: begin
                    if (imem_req_r) begin
                        // Once raised, the request stays up until answered.
                        if (bus.imem_valid) begin
                            instr_r    <= instr_t'(bus.imem_rdata);
                            imem_req_r <= 1'b0;
                            state_r    <= EXEC;
                        end else begin
                            imem_req_r <= 1'b1;
                        end
                    end else begin
                        imem_req_r <= run;
                    end
                end
                EXEC: begin
                    if (instr_r.j) begin
                        // Conditional jump not taken only when C=1 and cf=0.
                        pc_r       <= (instr_r.c && !cf_r) ? pc_inc_s : imm_pc_s;
                        imem_req_r <= run;
                        state_r    <= FETCH;
                    end else if (needs_mem(instr_r)) begin
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= (instr_r.d == D_MEM);
                        dmem_addr_r  <= instr_r.imm;
                        dmem_wdata_r <= ra_r;
                        state_r      <= MEM;
                    end else begin
                        case (instr_r.d)
                            D_RA:    ra_r <= exec_val_s;
                            D_RB:    rb_r <= exec_val_s;
                            D_RO:    ro_r <= ra_r;
                            default: ro_r <= ro_r;
                        endcase
                        if (alu_dest_s) begin
                            cf_r <= alu_cf_s;
                            zf_r <= alu_zf_s;
                        end
                        pc_r       <= pc_inc_s;
                        imem_req_r <= run;
                        state_r    <= FETCH;
                    end
                end
                MEM: begin
                    if (bus.dmem_valid) begin
                        if (!dmem_we_r) begin
                            case (instr_r.d)
                                D_RA:    ra_r <= bus.dmem_rdata;
                                D_RB:    rb_r <= bus.dmem_rdata;
                                D_RO:    ro_r <= ra_r;
                                default: ro_r <= ro_r;
                            endcase
                        end
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        pc_r       <= pc_inc_s;
                        imem_req_r <= run;
                        state_r    <= FETCH;
                    end else begin
                        dmem_req_r <= 1'b1;
                    end
                end
                default: begin
                    dmem_req_r <= 1'b0;
                    dmem_we_r  <= 1'b0;
                    imem_req_r <= 1'b0;
                    state_r    <= FETCH;
                end
            endcase
        end
    end

`ifdef K2_TRACE_EN
    logic              retire_s;
    logic              retire_valid_r;
    logic [PC_W-1:0]   retire_pc_r;
    logic [7:0]        retire_instr_r;

    // An instruction retires in EXEC unless it needs memory, else on dmem_valid.
    always_comb begin
        retire_s = ((state_r == EXEC) && !needs_mem(instr_r)) ||
                   ((state_r == MEM) && bus.dmem_valid);
    end

    // Trace capture: pc still holds the retiring instruction's address here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_valid_r <= 1'b0;
            retire_pc_r    <= {PC_W{1'b0}};
            retire_instr_r <= 8'h00;
        end else begin
            retire_valid_r <= retire_s;
            if (retire_s) begin
                retire_pc_r    <= pc_r;
                retire_instr_r <= instr_r;
            end else begin
                retire_pc_r    <= retire_pc_r;
                retire_instr_r <= retire_instr_r;
            end
        end
    end

    assign retire_valid = retire_valid_r;
    assign retire_pc    = retire_pc_r;
    assign retire_instr = retire_instr_r;
`endif

    assign bus.imem_req   = imem_req_r;
    assign bus.imem_addr  = pc_r;
    assign bus.dmem_req   = dmem_req_r;
    assign bus.dmem_we    = dmem_we_r;
    assign bus.dmem_addr  = dmem_addr_r;
    assign bus.dmem_wdata = dmem_wdata_r;

    assign pc   = pc_r;
    assign ra   = ra_r;
    assign ro   = ro_r;
    assign cf   = cf_r;
    assign zf   = zf_r;
    assign busy = (state_r != FETCH) || imem_req_r;
endmodule

// File: tb/tb_k2_mc_core.sv
// tb_k2_mc_core: directed self-checking bench for k2_mc_core (DATA_W=8, PC_W=4).
// Instruction memory answers in the request cycle; data memory answers after
// dmem_delay cycles of held request. Build with +define+K2_TRACE_EN for trace checks.
module tb_k2_mc_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] pc;
    logic [7:0] ra;
    logic [7:0] ro;
    logic       cf;
    logic       zf;
    logic       busy;
`ifdef K2_TRACE_EN
    logic       retire_valid;
    logic [3:0] retire_pc;
    logic [7:0] retire_instr;
    int         ret_count = 0;
    int         ret_snap;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0] imem [16];
    int         dmem_delay = 0;
    int         dcnt = 0;
    int         wr_count = 0;
    logic [2:0] last_waddr = 3'd0;
    logic [7:0] last_wdata = 8'd0;
    int         wr_snap;

    k2_mc_core_if #(.PC_W(4), .DATA_W(8)) bus_if ();

    k2_mc_core #(.DATA_W(8), .PC_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .bus   (bus_if),
        .pc    (pc),
        .ra    (ra),
        .ro    (ro),
        .cf    (cf),
        .zf    (zf),
        .busy  (busy)
`ifdef K2_TRACE_EN
        ,
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_instr (retire_instr)
`endif
    );

    always #5 clk = ~clk;

    assign bus_if.imem_valid = bus_if.imem_req;
    assign bus_if.imem_rdata = imem[bus_if.imem_addr];
    assign bus_if.dmem_valid = bus_if.dmem_req && (dcnt == dmem_delay);
    assign bus_if.dmem_rdata = {5'b10100, bus_if.dmem_addr};

    always @(posedge clk) begin
        if (bus_if.dmem_req) dcnt <= dcnt + 1;
        else dcnt <= 0;
        if (bus_if.dmem_req && bus_if.dmem_we && bus_if.dmem_valid) begin
            wr_count   <= wr_count + 1;
            last_waddr <= bus_if.dmem_addr;
            last_wdata <= bus_if.dmem_wdata;
        end
`ifdef K2_TRACE_EN
        if (retire_valid) ret_count <= ret_count + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with run=1; release 1 time unit after an edge so the next edge is P1.
    task automatic start();
        rst_n = 1'b0;
        run   = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // ---- Test 2: Ra<=5, Rb<=3, Ra<=Ra-Rb, Ro<=Ra
        for (int i = 0; i < 16; i++) imem[i] = 8'h08;
        imem[0] = 8'h0D; imem[1] = 8'h1B; imem[2] = 8'h04; imem[3] = 8'h20;
        start();
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick(7);
        chk("t2_ra", {24'd0, ra}, 32'h02);
        chk("t2_cf", {31'd0, cf}, 32'd1);
        chk("t2_zf", {31'd0, zf}, 32'd0);
        chk("t2_pc", {28'd0, pc}, 32'd3);
        tick(2);
        chk("t2_ro", {24'd0, ro}, 32'h02);

        // ---- Test 3: 0-1 = FF, FF+1 wraps with carry/zero, JC 6, J 2
        imem[0] = 8'h19; imem[1] = 8'h04; imem[2] = 8'h00; imem[3] = 8'hC6;
        imem[6] = 8'h82;
        start();
        tick(5);
        chk("t3_ra_ff", {24'd0, ra}, 32'hFF);
        chk("t3_cf_sub", {31'd0, cf}, 32'd0);
        tick(2);
        chk("t3_ra_0", {24'd0, ra}, 32'h00);
        chk("t3_cf_add", {31'd0, cf}, 32'd1);
        chk("t3_zf_add", {31'd0, zf}, 32'd1);
        tick(2);
        chk("t3_jc_pc", {28'd0, pc}, 32'd6);
        tick(2);
        chk("t3_j_pc", {28'd0, pc}, 32'd2);

        // ---- Test 4: store Ra=6 to mem[5] with 3 wait cycles, then read mem[3]
        for (int i = 0; i < 16; i++) imem[i] = 8'h08;
        imem[0] = 8'h0E; imem[1] = 8'h35; imem[2] = 8'h4B;
        dmem_delay = 3;
        start();
        wr_snap = wr_count;
        tick(5);
        chk("t4_req", {31'd0, bus_if.dmem_req}, 32'd1);
        chk("t4_we", {31'd0, bus_if.dmem_we}, 32'd1);
        chk("t4_addr", {29'd0, bus_if.dmem_addr}, 32'd5);
        chk("t4_wdata", {24'd0, bus_if.dmem_wdata}, 32'h06);
        tick(3);
        chk("t4_req_held", {31'd0, bus_if.dmem_req}, 32'd1);
        chk("t4_addr_held", {29'd0, bus_if.dmem_addr}, 32'd5);
        chk("t4_pc_held", {28'd0, pc}, 32'd1);
        chk("t4_no_early_wr", wr_count - wr_snap, 32'd0);
        tick(1);
        chk("t4_one_wr", wr_count - wr_snap, 32'd1);
        chk("t4_wr_addr", {29'd0, last_waddr}, 32'd5);
        chk("t4_wr_data", {24'd0, last_wdata}, 32'h06);
        chk("t4_pc", {28'd0, pc}, 32'd2);
        chk("t4_req_drop", {31'd0, bus_if.dmem_req}, 32'd0);
        dmem_delay = 0;
        tick(2);
        chk("t4_rd_we", {31'd0, bus_if.dmem_we}, 32'd0);
        chk("t4_rd_addr", {29'd0, bus_if.dmem_addr}, 32'd3);
        tick(1);
        chk("t4_rd_ra", {24'd0, ra}, 32'hA3);
        chk("t4_rd_pc", {28'd0, pc}, 32'd3);
        chk("t4_wr_total", wr_count - wr_snap, 32'd1);

        // ---- Test 5: run to pc=15, wrap to 0, run dropped during EXEC
        for (int i = 0; i < 16; i++) imem[i] = 8'h09;
        start();
`ifdef K2_TRACE_EN
        ret_snap = ret_count;
`endif
        tick(31);
        chk("t5_pc15", {28'd0, pc}, 32'd15);
        chk("t5_ra", {24'd0, ra}, 32'h01);
        tick(1);
        run = 1'b0;
        tick(1);
        chk("t5_wrap", {28'd0, pc}, 32'd0);
        chk("t5_ireq_off", {31'd0, bus_if.imem_req}, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
`ifdef K2_TRACE_EN
        chk("t6_rv", {31'd0, retire_valid}, 32'd1);
        chk("t6_rpc", {28'd0, retire_pc}, 32'd15);
        chk("t6_rinstr", {24'd0, retire_instr}, 32'h09);
`endif
        tick(2);
        chk("t5_ireq_stays", {31'd0, bus_if.imem_req}, 32'd0);
        chk("t5_pc_stays", {28'd0, pc}, 32'd0);
`ifdef K2_TRACE_EN
        chk("t6_count", ret_count - ret_snap, 32'd16);
        chk("t6_rv_low", {31'd0, retire_valid}, 32'd0);
`endif

        // ---- Test 1: reset while a store is waiting in MEM
        imem[0] = 8'h35;
        dmem_delay = 10;
        start();
        wr_snap = wr_count;
        tick(3);
        chk("t1_in_mem", {31'd0, bus_if.dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_dreq", {31'd0, bus_if.dmem_req}, 32'd0);
        chk("t1_dwe", {31'd0, bus_if.dmem_we}, 32'd0);
        chk("t1_daddr", {29'd0, bus_if.dmem_addr}, 32'd0);
        chk("t1_ireq", {31'd0, bus_if.imem_req}, 32'd0);
        chk("t1_pc", {28'd0, pc}, 32'd0);
        chk("t1_ra_ro", {16'd0, ra, ro}, 32'd0);
        chk("t1_flags", {30'd0, cf, zf}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        run = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(12);
        chk("t1_no_write", wr_count - wr_snap, 32'd0);
        chk("t1_stay_idle", {31'd0, bus_if.imem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
